// File: rtl/decode_pkg.sv
// Shared types, encodings and immediate helpers for the RV32I decode stage.
// Widths mirror the legacy constants header so older blocks can share the same numbers.
package decode_pkg;

    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned INSTR_WIDTH    = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned OP_SEL_WIDTH   = 2;
    localparam int unsigned ALU_OP_WIDTH   = 4;
    localparam int unsigned FU_SEL_WIDTH   = 3;

    localparam logic [OP_SEL_WIDTH-1:0] OP_SEL_RS2      = 2'd0;
    localparam logic [OP_SEL_WIDTH-1:0] OP_SEL_IMM      = 2'd1;
    localparam logic [OP_SEL_WIDTH-1:0] OP_SEL_PC_IMM   = 2'd2;
    localparam logic [OP_SEL_WIDTH-1:0] OP_SEL_ZERO_IMM = 2'd3;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 4'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LT   = 4'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 4'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 4'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 4'd15;

    localparam logic [FU_SEL_WIDTH-1:0] FU_NONE   = 3'd0;
    localparam logic [FU_SEL_WIDTH-1:0] FU_ALU    = 3'd1;
    localparam logic [FU_SEL_WIDTH-1:0] FU_BRANCH = 3'd2;
    localparam logic [FU_SEL_WIDTH-1:0] FU_LSU    = 3'd3;
    localparam logic [FU_SEL_WIDTH-1:0] FU_SYS    = 3'd4;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
    } decode_in_t;

    typedef struct packed {
        logic [OP_SEL_WIDTH-1:0]   op_sel;
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [INSTR_WIDTH-1:0]    imm;
        logic [FU_SEL_WIDTH-1:0]   fu_sel;
        logic                      illegal;
    } decode_out_t;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // alt is instr[30] only where it distinguishes SUB/SRA.
    function automatic logic [ALU_OP_WIDTH-1:0] alu_from_f3(input logic [2:0] f3,
                                                            input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I base decoder: raw instruction to operand/ALU/FU controls.
// Illegal encodings collapse to a zeroed entry with only the illegal flag set.
module rv32i_decoder
    import decode_pkg::*;
(
    input  decode_in_t  fetch,
    output decode_out_t dec
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        bad;

    assign instr  = fetch.instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        dec    = '0;
        bad    = 1'b0;
        dec.rd = instr[11:7];
        if (instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    dec.imm    = imm_u(instr);
                    dec.op_sel = OP_SEL_ZERO_IMM;
                    dec.fu_sel = FU_ALU;
                end
                OPC_AUIPC: begin
                    dec.imm    = imm_u(instr);
                    dec.op_sel = OP_SEL_PC_IMM;
                    dec.fu_sel = FU_ALU;
                end
                OPC_JAL: begin
                    dec.imm    = imm_j(instr);
                    dec.op_sel = OP_SEL_PC_IMM;
                    dec.fu_sel = FU_BRANCH;
                end
                OPC_JALR: begin
                    bad        = (f3 != 3'd0);
                    dec.rs1    = instr[19:15];
                    dec.imm    = imm_i(instr);
                    dec.op_sel = OP_SEL_IMM;
                    dec.fu_sel = FU_BRANCH;
                end
                OPC_BRANCH: begin
                    dec.rd     = '0;
                    dec.rs1    = instr[19:15];
                    dec.rs2    = instr[24:20];
                    dec.imm    = imm_b(instr);
                    dec.op_sel = OP_SEL_RS2;
                    dec.fu_sel = FU_BRANCH;
                    case (f3)
                        3'd0:    dec.alu_op = ALU_EQ;
                        3'd1:    dec.alu_op = ALU_NE;
                        3'd4:    dec.alu_op = ALU_LT;
                        3'd5:    dec.alu_op = ALU_GE;
                        3'd6:    dec.alu_op = ALU_LTU;
                        3'd7:    dec.alu_op = ALU_GEU;
                        default: bad = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    bad        = (f3 == 3'd3) || (f3 > 3'd5);
                    dec.rs1    = instr[19:15];
                    dec.imm    = imm_i(instr);
                    dec.op_sel = OP_SEL_IMM;
                    dec.fu_sel = FU_LSU;
                end
                OPC_STORE: begin
                    bad        = (f3 > 3'd2);
                    dec.rd     = '0;
                    dec.rs1    = instr[19:15];
                    dec.rs2    = instr[24:20];
                    dec.imm    = imm_s(instr);
                    dec.op_sel = OP_SEL_IMM;
                    dec.fu_sel = FU_LSU;
                end
                OPC_OP_IMM: begin
                    // Shift immediates reuse the funct7 field, so only those constrain it.
                    bad        = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                                 ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
                    dec.rs1    = instr[19:15];
                    dec.imm    = imm_i(instr);
                    dec.alu_op = alu_from_f3(f3, (f3 == 3'd5) && instr[30]);
                    dec.op_sel = OP_SEL_IMM;
                    dec.fu_sel = FU_ALU;
                end
                OPC_OP: begin
                    bad        = !((f7 == 7'h00) ||
                                   ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
                    dec.rs1    = instr[19:15];
                    dec.rs2    = instr[24:20];
                    dec.alu_op = alu_from_f3(f3, instr[30]);
                    dec.op_sel = OP_SEL_RS2;
                    dec.fu_sel = FU_ALU;
                end
                OPC_MISC_MEM: begin
                    bad        = (f3 > 3'd1);
                    dec.rs1    = instr[19:15];
                    dec.imm    = imm_i(instr);
                    dec.op_sel = OP_SEL_IMM;
                    dec.fu_sel = FU_SYS;
                end
                OPC_SYSTEM: begin
                    // funct3==0 only admits ECALL and EBREAK.
                    bad        = (f3 == 3'd4) ||
                                 ((f3 == 3'd0) && (instr[31:7] != 25'd0) &&
                                  (instr[31:7] != {12'd1, 13'd0}));
                    dec.rs1    = instr[19:15];
                    dec.imm    = imm_i(instr);
                    dec.op_sel = OP_SEL_IMM;
                    dec.fu_sel = FU_SYS;
                end
                default: bad = 1'b1;
            endcase
        end
        if (bad) begin
            dec         = '0;
            dec.alu_op  = ALU_ADD;
            dec.fu_sel  = FU_NONE;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage_mt.sv
// Multithreaded decode stage: handshaked head register plus one-entry skid buffer,
// per-thread flush and per-thread saturating illegal-instruction counters.
module decode_stage_mt
    import decode_pkg::*;
#(
    parameter int unsigned XLEN      = DEF_XLEN,
    parameter int unsigned THREADS   = 8,
    parameter int unsigned ILL_CNT_W = 8,
    localparam int unsigned TID_W    = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [XLEN-1:0]            in_pc_i,
    input  logic [TID_W-1:0]           in_tid_i,
    input  logic [31:0]                in_instr_i,
    input  logic                       stall_i,
    input  logic [THREADS-1:0]         flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OP_SEL_WIDTH-1:0]    out_op_sel_o,
    output logic [ALU_OP_WIDTH-1:0]    out_alu_op_o,
    output logic [REG_ADDR_WIDTH-1:0]  out_rs1_o,
    output logic [REG_ADDR_WIDTH-1:0]  out_rs2_o,
    output logic [REG_ADDR_WIDTH-1:0]  out_rd_o,
    output logic [XLEN-1:0]            out_imm_o,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [TID_W-1:0]           out_tid_o,
    output logic [FU_SEL_WIDTH-1:0]    out_fu_sel_o,
    output logic                       out_illegal_o,
    input  logic [THREADS-1:0]         ill_clr_i,
    output logic [THREADS*ILL_CNT_W-1:0] ill_cnt_o
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [TID_W-1:0] tid;
        decode_out_t      dec;
    } entry_t;

    entry_t                head_q, head_d, skid_q, skid_d, in_entry;
    logic                  head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
    logic                  in_ready_q;
    logic [ILL_CNT_W-1:0]  cnt_q [THREADS];
    logic [ILL_CNT_W-1:0]  cnt_d [THREADS];
    decode_in_t            dec_in;
    decode_out_t           dec_out;
    logic [31:0]           tid_ext;
    logic                  tid_oor, drain, accept, head_live, skid_live, in_live;

    function automatic logic killed(input logic [TID_W-1:0] tid,
                                    input logic [THREADS-1:0] mask);
        logic k;
        k = 1'b0;
        for (int unsigned t = 0; t < THREADS; t++) begin
            if (mask[t] && (tid == TID_W'(t))) k = 1'b1;
        end
        return k;
    endfunction

    assign dec_in.instr = in_instr_i;

    rv32i_decoder u_dec (
        .fetch (dec_in),
        .dec   (dec_out)
    );

    // Thread ids past THREADS can only appear when THREADS is not a power of two.
    assign tid_ext = 32'(in_tid_i);
    assign tid_oor = (tid_ext >= THREADS);

    always_comb begin
        in_entry.pc  = in_pc_i;
        in_entry.tid = in_tid_i;
        in_entry.dec = dec_out;
        if (tid_oor) begin
            in_entry.dec         = '0;
            in_entry.dec.illegal = 1'b1;
        end
    end

    assign drain     = head_valid_q & out_ready_i & ~stall_i;
    assign accept    = in_valid_i & in_ready_q;
    assign head_live = head_valid_q & ~drain & ~killed(head_q.tid, flush_i);
    assign skid_live = skid_valid_q & ~killed(skid_q.tid, flush_i);
    assign in_live   = accept & ~killed(in_tid_i, flush_i);

    // Survivors are compacted in age order: head, then skid, then the new entry.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        if (head_live) begin
            head_valid_d = 1'b1;
            if (skid_live) begin
                skid_valid_d = 1'b1;
            end else if (in_live) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end else if (skid_live) begin
            head_d       = skid_q;
            head_valid_d = 1'b1;
            if (in_live) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end else if (in_live) begin
            head_d       = in_entry;
            head_valid_d = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned t = 0; t < THREADS; t++) begin
            cnt_d[t] = cnt_q[t];
            if (ill_clr_i[t]) begin
                cnt_d[t] = '0;
            end else if (in_live && in_entry.dec.illegal && !tid_oor &&
                         (in_tid_i == TID_W'(t)) && (cnt_q[t] != '1)) begin
                cnt_d[t] = cnt_q[t] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            for (int unsigned t = 0; t < THREADS; t++) cnt_q[t] <= '0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
            for (int unsigned t = 0; t < THREADS; t++) cnt_q[t] <= cnt_d[t];
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = head_valid_q;
    assign out_op_sel_o  = head_q.dec.op_sel;
    assign out_alu_op_o  = head_q.dec.alu_op;
    assign out_rs1_o     = head_q.dec.rs1;
    assign out_rs2_o     = head_q.dec.rs2;
    assign out_rd_o      = head_q.dec.rd;
    assign out_imm_o     = XLEN'($signed(head_q.dec.imm));
    assign out_pc_o      = head_q.pc;
    assign out_tid_o     = head_q.tid;
    assign out_fu_sel_o  = head_q.dec.fu_sel;
    assign out_illegal_o = head_q.dec.illegal;

    always_comb begin
        ill_cnt_o = '0;
        for (int unsigned t = 0; t < THREADS; t++) begin
            ill_cnt_o[t*ILL_CNT_W +: ILL_CNT_W] = cnt_q[t];
        end
    end

endmodule

// File: tb/tb_decode_stage_mt.sv
// Scoreboard bench for decode_stage_mt: directed vectors push expected entries,
// a monitor pops and compares on every output handshake.
module tb_decode_stage_mt;
    import decode_pkg::*;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned THREADS   = 8;
    localparam int unsigned ILL_CNT_W = 8;
    localparam int unsigned TID_W     = 3;

    logic                        clk, rst;
    logic                        in_valid_i, in_ready_o, stall_i, out_valid_o, out_ready_i;
    logic [XLEN-1:0]             in_pc_i, out_imm_o, out_pc_o;
    logic [TID_W-1:0]            in_tid_i, out_tid_o;
    logic [31:0]                 in_instr_i;
    logic [THREADS-1:0]          flush_i, ill_clr_i;
    logic [OP_SEL_WIDTH-1:0]     out_op_sel_o;
    logic [ALU_OP_WIDTH-1:0]     out_alu_op_o;
    logic [REG_ADDR_WIDTH-1:0]   out_rs1_o, out_rs2_o, out_rd_o;
    logic [FU_SEL_WIDTH-1:0]     out_fu_sel_o;
    logic                        out_illegal_o;
    logic [THREADS*ILL_CNT_W-1:0] ill_cnt_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  tid;
        logic [1:0]  op;
        logic [3:0]  alu;
        logic [2:0]  fu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [63:0] CNT_BASE = 64'h0001_0001_0000_0000;

    decode_stage_mt #(
        .XLEN      (XLEN),
        .THREADS   (THREADS),
        .ILL_CNT_W (ILL_CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_pc_i       (in_pc_i),
        .in_tid_i      (in_tid_i),
        .in_instr_i    (in_instr_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_op_sel_o  (out_op_sel_o),
        .out_alu_op_o  (out_alu_op_o),
        .out_rs1_o     (out_rs1_o),
        .out_rs2_o     (out_rs2_o),
        .out_rd_o      (out_rd_o),
        .out_imm_o     (out_imm_o),
        .out_pc_o      (out_pc_o),
        .out_tid_o     (out_tid_o),
        .out_fu_sel_o  (out_fu_sel_o),
        .out_illegal_o (out_illegal_o),
        .ill_clr_i     (ill_clr_i),
        .ill_cnt_o     (ill_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] tid,
                                input logic [1:0] op, input logic [3:0] alu,
                                input logic [2:0] fu, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.tid = tid; e.op = op; e.alu = alu; e.fu = fu;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] pc, input logic [2:0] tid);
        return mk(pc, tid, OP_SEL_RS2, ALU_ADD, FU_NONE, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    endfunction

    // Monitor: every handshake seen just before a rising edge must match the queue head.
    initial begin
        exp_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid_o && out_ready_i && !stall_i) begin
                a.pc = out_pc_o; a.tid = out_tid_o; a.op = out_op_sel_o;
                a.alu = out_alu_op_o; a.fu = out_fu_sel_o; a.rs1 = out_rs1_o;
                a.rs2 = out_rs2_o; a.rd = out_rd_o; a.imm = out_imm_o;
                a.ill = out_illegal_o;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL entry unexpected actual pc=%h tid=%0d required none",
                             a.pc, a.tid);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display({"FAIL entry actual pc=%h tid=%0d op=%0d alu=%0d fu=%0d ",
                                  "rs1=%0d rs2=%0d rd=%0d imm=%h ill=%0b required pc=%h ",
                                  "tid=%0d op=%0d alu=%0d fu=%0d rs1=%0d rs2=%0d rd=%0d ",
                                  "imm=%h ill=%0b"},
                                 a.pc, a.tid, a.op, a.alu, a.fu, a.rs1, a.rs2, a.rd,
                                 a.imm, a.ill, e.pc, e.tid, e.op, e.alu, e.fu, e.rs1,
                                 e.rs2, e.rd, e.imm, e.ill);
                    end
                end
            end
        end
    end

    // Returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] instr, input exp_t e, input bit push);
        bit r;
        in_valid_i = 1'b1;
        in_pc_i    = e.pc;
        in_tid_i   = e.tid;
        in_instr_i = instr;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            r = in_ready_o;
            @(posedge clk);
            #1;
            if (r) begin
                if (push) exp_q.push_back(e);
                in_valid_i = 1'b0;
                return;
            end
        end
        in_valid_i = 1'b0;
        checks++;
        failures++;
        $display("FAIL send_timeout actual=no_accept required=accept pc=%h", e.pc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid_i = 1'b0; in_pc_i = '0; in_tid_i = '0; in_instr_i = '0;
        stall_i = 1'b0; flush_i = '0; ill_clr_i = '0; out_ready_i = 1'b0;

        #3;
        check("reset_out_valid", 64'(out_valid_o), 64'd0);
        check("reset_in_ready", 64'(in_ready_o), 64'd0);
        check("reset_cnt", ill_cnt_o, 64'd0);
        check("reset_imm", 64'(out_imm_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(in_ready_o), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 64'(in_ready_o), 64'd1);

        // Basic decode coverage with full throughput.
        out_ready_i = 1'b1;
        send(32'h00B50633, mk(32'h100, 3'd3, OP_SEL_RS2, ALU_ADD, FU_ALU, 5'd10, 5'd11,
                              5'd12, 32'd0, 1'b0), 1'b1);
        check("add_latency_valid", 64'(out_valid_o), 64'd1);
        send(32'h00208463, mk(32'h104, 3'd3, OP_SEL_RS2, ALU_EQ, FU_BRANCH, 5'd1, 5'd2,
                              5'd0, 32'd8, 1'b0), 1'b1);
        send(32'hFE312E23, mk(32'h108, 3'd0, OP_SEL_IMM, ALU_ADD, FU_LSU, 5'd2, 5'd3,
                              5'd0, 32'hFFFF_FFFC, 1'b0), 1'b1);
        send(32'h409403B3, mk(32'h10C, 3'd7, OP_SEL_RS2, ALU_SUB, FU_ALU, 5'd8, 5'd9,
                              5'd7, 32'd0, 1'b0), 1'b1);
        send(32'h00B50630, mk_ill(32'h110, 3'd4), 1'b1);
        send(32'h02B50633, mk_ill(32'h114, 3'd6), 1'b1);
        wait_drain();
        check("cnt_after_basic", ill_cnt_o, CNT_BASE);

        // Back-pressure: head then skid fill, ready drops, then drain in order.
        out_ready_i = 1'b0;
        send(32'hFFF00093, mk(32'h200, 3'd0, OP_SEL_IMM, ALU_ADD, FU_ALU, 5'd0, 5'd0,
                              5'd1, 32'hFFFF_FFFF, 1'b0), 1'b1);
        send(32'h12345137, mk(32'h204, 3'd0, OP_SEL_ZERO_IMM, ALU_ADD, FU_ALU, 5'd0, 5'd0,
                              5'd2, 32'h1234_5000, 1'b0), 1'b1);
        check("bp_in_ready_low", 64'(in_ready_o), 64'd0);
        tick(2);
        check("bp_head_valid", 64'(out_valid_o), 64'd1);
        check("bp_head_stable", 64'(out_imm_o), 64'hFFFF_FFFF);
        out_ready_i = 1'b1;
        wait_drain();
        check("bp_empty_after", 64'(out_valid_o), 64'd0);
        check("bp_ready_after", 64'(in_ready_o), 64'd1);

        // Flush thread 2 in head while thread 5 sits in skid.
        out_ready_i = 1'b0;
        send(32'h00500293, mk(32'h300, 3'd2, OP_SEL_IMM, ALU_ADD, FU_ALU, 5'd0, 5'd0,
                              5'd5, 32'd5, 1'b0), 1'b0);
        send(32'h00600313, mk(32'h304, 3'd5, OP_SEL_IMM, ALU_ADD, FU_ALU, 5'd0, 5'd0,
                              5'd6, 32'd6, 1'b0), 1'b1);
        flush_i = 8'b0000_0100;
        tick(1);
        flush_i = '0;
        check("flush_head_valid", 64'(out_valid_o), 64'd1);
        check("flush_head_tid", 64'(out_tid_o), 64'd5);
        check("flush_head_rd", 64'(out_rd_o), 64'd6);
        check("flush_ready", 64'(in_ready_o), 64'd1);
        out_ready_i = 1'b1;
        wait_drain();

        // Illegal counting and saturation on thread 1.
        for (int i = 0; i < 300; i++) begin
            send(32'hFFFF_FFFF, mk_ill(32'h1000 + 32'(i) * 4, 3'd1), 1'b1);
            if (i == 9) check("cnt_after_10", ill_cnt_o, CNT_BASE | 64'h0A00);
        end
        check("cnt_saturated", ill_cnt_o, CNT_BASE | 64'hFF00);
        ill_clr_i = 8'b0000_0010;
        send(32'hFFFF_FFFF, mk_ill(32'h2000, 3'd1), 1'b1);
        ill_clr_i = '0;
        check("cnt_clear_wins", ill_cnt_o, CNT_BASE);
        wait_drain();

        // Legacy stall with out_ready high.
        stall_i = 1'b1;
        send(32'hFFF00093, mk(32'h400, 3'd0, OP_SEL_IMM, ALU_ADD, FU_ALU, 5'd0, 5'd0,
                              5'd1, 32'hFFFF_FFFF, 1'b0), 1'b1);
        tick(3);
        check("stall_valid", 64'(out_valid_o), 64'd1);
        check("stall_imm_stable", 64'(out_imm_o), 64'hFFFF_FFFF);
        send(32'h12345137, mk(32'h404, 3'd0, OP_SEL_ZERO_IMM, ALU_ADD, FU_ALU, 5'd0, 5'd0,
                              5'd2, 32'h1234_5000, 1'b0), 1'b1);
        check("stall_ready_low", 64'(in_ready_o), 64'd0);
        check("stall_rd_stable", 64'(out_rd_o), 64'd1);
        stall_i = 1'b0;
        wait_drain();
        send(32'h00B50633, mk(32'h408, 3'd3, OP_SEL_RS2, ALU_ADD, FU_ALU, 5'd10, 5'd11,
                              5'd12, 32'd0, 1'b0), 1'b1);
        check("resume_latency_valid", 64'(out_valid_o), 64'd1);
        wait_drain();

        // Asynchronous reset with head and skid both occupied.
        out_ready_i = 1'b0;
        send(32'hFFFF_FFFF, mk_ill(32'h500, 3'd2), 1'b0);
        send(32'hFFFF_FFFF, mk_ill(32'h504, 3'd3), 1'b0);
        check("pre_reset_full", 64'(in_ready_o), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid_o), 64'd0);
        check("async_rst_ready", 64'(in_ready_o), 64'd0);
        check("async_rst_cnt", ill_cnt_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready_o), 64'd1);
        check("post_rst_valid", 64'(out_valid_o), 64'd0);
        check("post_rst_cnt", ill_cnt_o, 64'd0);

        tick(2);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
